maze_env_step: RTL and testbench
================================

MAZE_ENV_STEP -- requirements
Module: maze_env_step

Interface
REQ-001 SHALL have parameter ROWS, default 6, grid rows.
REQ-002 SHALL have parameter COLS, default 6, grid columns.
REQ-003 SHALL have parameter MAX_STEPS, default 64, steps before a forced episode timeout.
REQ-004 SHALL have parameter RW, default 8, signed reward width.
REQ-005 SHALL have parameters R_GOAL = 100, R_WALL = -10 and R_STEP = -1 (RW-bit signed), giving the goal, illegal-move and ordinary-step rewards.
REQ-006 SHALL derive N = ROWS*COLS and SW = $clog2(N+1). States are numbered 1..N row-major; state 1 is top-left.
REQ-007 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- ep_start  in  1  pulse; loads start_state and begins an episode.
- start_state  in  SW  episode start cell.
- target_state  in  SW  goal cell.
- blocked  in  N  bitmap; bit k-1 set means state k is impassable.
- in_valid  in  1  action offered.
- in_ready  out  1  action accepted this cycle.
- action  in  2  0 = down (+COLS), 1 = right (+1), 2 = up (-COLS), 3 = left (-1).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- next_state  out  SW  state after the step.
- reward  out  RW  signed reward.
- terminal  out  1  episode ended (goal or timeout).
- timeout  out  1  episode ended by MAX_STEPS.
- cfg_err  out  1  sticky; set when start_state is invalid.
- episode_count  out  16  completed episodes, wrapping.
- cur_state  out  SW  current agent position.

Function
REQ-008 SHALL implement the FSM IDLE -> EVAL -> RESP -> IDLE. The action handshake completes when in_valid and in_ready are both high. EVAL always lasts exactly one cycle. Leave RESP when out_valid and out_ready are both high.
REQ-009 in_ready SHALL be 1 only when the FSM is in IDLE and ep_start is low. ep_start therefore has priority over an action in the same cycle.
REQ-010 out_valid SHALL rise exactly 2 cycles after the accepting edge. It and all result outputs SHALL hold stable until out_ready is high.
REQ-011 ep_start in IDLE SHALL load cur_state from start_state and clear the step counter. ep_start SHALL be ignored in EVAL and RESP.
REQ-012 start_state is invalid when it is 0, greater than N, or blocked. An ep_start with an invalid start_state SHALL set cfg_err and leave cur_state unchanged.
REQ-013 Row and column SHALL be tracked in registers alongside cur_state; no divider or modulo hardware is permitted.
REQ-014 An action is legal only if the move stays inside the grid and the candidate cell is not blocked:
- action 0 requires row < ROWS-1.
- action 1 requires col < COLS-1; there is no wrap to the next row.
- action 2 requires row > 0.
- action 3 requires col > 0.
REQ-015 An illegal action SHALL give next_state = cur_state and reward = R_WALL.
REQ-016 A legal action SHALL give next_state = candidate. reward SHALL be R_GOAL if candidate equals target_state, otherwise R_STEP.
REQ-017 Reaching the goal SHALL set terminal = 1, increment episode_count (wrap 0xFFFF -> 0), and load cur_state from start_state on the RESP exit.
REQ-018 The step counter SHALL increment on every accepted action. When an accepted action is step MAX_STEPS and the goal was not reached, set terminal = 1 and timeout = 1, increment episode_count, and restart at start_state.
REQ-019 If the goal is reached and the timeout falls on the same step, goal SHALL win: timeout = 0, reward = R_GOAL.
REQ-020 On a non-terminal step, cur_state SHALL update to next_state on the RESP exit.
REQ-021 Changes to blocked or target_state SHALL be sampled in EVAL only.

Reset
REQ-022 While rst is low at a clock edge, SHALL set:
- FSM = IDLE, in_ready = 1 (after release), out_valid = 0.
- next_state = 0, reward = 0, terminal = 0, timeout = 0, cfg_err = 0.
- episode_count = 0, step counter = 0, cur_state = 0 (unloaded).
REQ-023 Reset in EVAL or RESP SHALL abandon the step; no counter SHALL update.
REQ-024 While cur_state = 0, an accepted action SHALL return next_state = 0, reward = R_WALL, terminal = 0.

Structure
REQ-025 Package maze_pkg SHALL hold the action enum (DOWN, RIGHT, UP, LEFT), the FSM state enum, and the reward defaults.
REQ-026 Candidate and legality computation SHALL live in one combinational sub-module, maze_move_eval (inputs: row, col, action, blocked; outputs: candidate, legal).

Verification (6x6 grid, start 1, target 36)
REQ-027 ep_start, then action 1 -> next_state 2, reward -1, terminal 0, out_valid 2 cycles after accept.
REQ-028 cur_state 6, action 1 -> next_state 6, reward -10. Then blocked bit 13 set (state 14 blocked), cur_state 8, action 0 -> stays 8, reward -10.
REQ-029 cur_state 30, action 0 -> next_state 36, reward 100, terminal 1, episode_count 1; the following cur_state is 1.
REQ-030 MAX_STEPS = 4, four legal non-goal steps -> the 4th returns terminal 1, timeout 1, and cur_state returns to 1.
REQ-031 Hold out_ready low for 5 cycles in RESP -> outputs stable and in_ready 0 throughout. Separately, ep_start with start_state 0 -> cfg_err 1 and cur_state unchanged.
REQ-032 Assert rst during RESP -> all outputs at reset values on the next cycle; episode_count not incremented.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and reward defaults for the grid-maze environment step engine.
package maze_pkg;

   typedef enum logic [1:0] {
      DOWN  = 2'd0,
      RIGHT = 2'd1,
      UP    = 2'd2,
      LEFT  = 2'd3
   } action_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EVAL = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam int R_GOAL_DEF = 100;
   localparam int R_WALL_DEF = -10;
   localparam int R_STEP_DEF = -1;

endpackage

// File: rtl/maze_move_eval.sv
// Combinational move evaluation: candidate cell and legality from the tracked row/col.
module maze_move_eval
   import maze_pkg::*;
#(
   parameter int ROWS = 6,
   parameter int COLS = 6,
   parameter int N    = ROWS * COLS,
   parameter int SW   = $clog2(N + 1),
   parameter int RBW  = (ROWS > 1) ? $clog2(ROWS) : 1,
   parameter int CBW  = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic [RBW-1:0] row,
   input  logic [CBW-1:0] col,
   input  action_t        action,
   input  logic [N-1:0]   blocked,
   output logic [SW-1:0]  candidate,
   output logic [RBW-1:0] cand_row,
   output logic [CBW-1:0] cand_col,
   output logic           legal
);

   logic in_grid;
   logic cand_blk;

   always_comb begin
      cand_row = row;
      cand_col = col;
      in_grid  = 1'b0;
      cand_blk = 1'b0;
      case (action)
         DOWN: if (row < RBW'(ROWS - 1)) begin
            in_grid  = 1'b1;
            cand_row = row + RBW'(1);
         end
         RIGHT: if (col < CBW'(COLS - 1)) begin
            in_grid  = 1'b1;
            cand_col = col + CBW'(1);
         end
         UP: if (row > '0) begin
            in_grid  = 1'b1;
            cand_row = row - RBW'(1);
         end
         LEFT: if (col > '0) begin
            in_grid  = 1'b1;
            cand_col = col - CBW'(1);
         end
         default: in_grid = 1'b0;
      endcase
      // Constant-multiply only; row/col never need to be recovered from a state number here.
      candidate = SW'(int'(cand_row) * COLS + int'(cand_col) + 1);
      for (int unsigned k = 0; k < N; k++) begin
         if (candidate == SW'(k + 1)) cand_blk = blocked[k];
      end
      legal = in_grid && !cand_blk;
   end

endmodule

// File: rtl/maze_env_step.sv
// Grid-maze environment: one agent step per action handshake, with goal/timeout
// episode handling and a registered result held until the consumer accepts it.
module maze_env_step
   import maze_pkg::*;
#(
   parameter int ROWS      = 6,
   parameter int COLS      = 6,
   parameter int MAX_STEPS = 64,
   parameter int RW        = 8,
   parameter logic signed [RW-1:0] R_GOAL = RW'(R_GOAL_DEF),
   parameter logic signed [RW-1:0] R_WALL = RW'(R_WALL_DEF),
   parameter logic signed [RW-1:0] R_STEP = RW'(R_STEP_DEF),
   localparam int N  = ROWS * COLS,
   localparam int SW = $clog2(N + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ep_start,
   input  logic [SW-1:0]        start_state,
   input  logic [SW-1:0]        target_state,
   input  logic [N-1:0]         blocked,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           action,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SW-1:0]        next_state,
   output logic signed [RW-1:0] reward,
   output logic                 terminal,
   output logic                 timeout,
   output logic                 cfg_err,
   output logic [15:0]          episode_count,
   output logic [SW-1:0]        cur_state
);

   localparam int RBW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CBW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int SCW = $clog2(MAX_STEPS + 1);

   state_t         state, state_nxt;
   action_t        act_r;
   logic [RBW-1:0] row, nrow, ld_row, cand_row;
   logic [CBW-1:0] col, ncol, ld_col, cand_col;
   logic [SCW-1:0] step_cnt;
   logic [SW-1:0]  candidate;
   logic           legal;
   logic           start_blk, start_ok;
   logic           is_goal, last_step;

   maze_move_eval #(
      .ROWS (ROWS),
      .COLS (COLS),
      .N    (N),
      .SW   (SW),
      .RBW  (RBW),
      .CBW  (CBW)
   ) u_move_eval (
      .row       (row),
      .col       (col),
      .action    (act_r),
      .blocked   (blocked),
      .candidate (candidate),
      .cand_row  (cand_row),
      .cand_col  (cand_col),
      .legal     (legal)
   );

   // Start cell decode by comparing against each row's base; no division needed.
   always_comb begin
      start_blk = 1'b0;
      ld_row    = '0;
      ld_col    = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (start_state == SW'(k + 1)) start_blk = blocked[k];
      end
      for (int unsigned r = 0; r < ROWS; r++) begin
         if (start_state > SW'(r * COLS)) begin
            ld_row = RBW'(r);
            ld_col = CBW'(start_state - SW'(r * COLS + 1));
         end
      end
      start_ok  = (start_state != '0) && (start_state <= SW'(N)) && !start_blk;
      last_step = (step_cnt == SCW'(MAX_STEPS));
      is_goal   = legal && (candidate == target_state);
   end

   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = !ep_start;
            if (!ep_start && in_valid) state_nxt = S_EVAL;
         end
         S_EVAL: state_nxt = S_RESP;
         S_RESP: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         act_r         <= DOWN;
         cur_state     <= '0;
         row           <= '0;
         col           <= '0;
         step_cnt      <= '0;
         next_state    <= '0;
         nrow          <= '0;
         ncol          <= '0;
         reward        <= '0;
         terminal      <= 1'b0;
         timeout       <= 1'b0;
         cfg_err       <= 1'b0;
         episode_count <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (ep_start) begin
                  if (start_ok) begin
                     cur_state <= start_state;
                     row       <= ld_row;
                     col       <= ld_col;
                     step_cnt  <= '0;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end else if (in_valid) begin
                  act_r <= action_t'(action);
                  if (cur_state != '0) step_cnt <= step_cnt + SCW'(1);
               end
            end
            S_EVAL: begin
               if (cur_state == '0) begin
                  next_state <= '0;
                  nrow       <= '0;
                  ncol       <= '0;
                  reward     <= R_WALL;
                  terminal   <= 1'b0;
                  timeout    <= 1'b0;
               end else if (!legal) begin
                  next_state <= cur_state;
                  nrow       <= row;
                  ncol       <= col;
                  reward     <= R_WALL;
                  terminal   <= last_step;
                  timeout    <= last_step;
               end else begin
                  next_state <= candidate;
                  nrow       <= cand_row;
                  ncol       <= cand_col;
                  reward     <= is_goal ? R_GOAL : R_STEP;
                  terminal   <= is_goal || last_step;
                  timeout    <= !is_goal && last_step;
               end
            end
            S_RESP: begin
               if (out_ready) begin
                  if (terminal) begin
                     episode_count <= episode_count + 16'd1;
                     step_cnt      <= '0;
                     if (start_ok) begin
                        cur_state <= start_state;
                        row       <= ld_row;
                        col       <= ld_col;
                     end else begin
                        cfg_err   <= 1'b1;
                        cur_state <= '0;
                        row       <= '0;
                        col       <= '0;
                     end
                  end else begin
                     cur_state <= next_state;
                     row       <= nrow;
                     col       <= ncol;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_maze_env_step.sv
// Scoreboard bench for maze_env_step on a 6x6 grid, start 1, target 36.
module tb_maze_env_step;

   localparam int ROWS = 6;
   localparam int COLS = 6;
   localparam int N    = ROWS * COLS;
   localparam int SW   = $clog2(N + 1);
   localparam int RW   = 8;
   localparam int MS   = 64;

   logic                 clk;
   logic                 rst;
   logic                 ep_start;
   logic [SW-1:0]        start_state;
   logic [SW-1:0]        target_state;
   logic [N-1:0]         blocked;
   logic                 in_valid;
   logic                 in_ready;
   logic [1:0]           action;
   logic                 out_valid;
   logic                 out_ready;
   logic [SW-1:0]        next_state;
   logic signed [RW-1:0] reward;
   logic                 terminal;
   logic                 timeout;
   logic                 cfg_err;
   logic [15:0]          episode_count;
   logic [SW-1:0]        cur_state;

   maze_env_step #(
      .ROWS      (ROWS),
      .COLS      (COLS),
      .MAX_STEPS (MS),
      .RW        (RW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ep_start      (ep_start),
      .start_state   (start_state),
      .target_state  (target_state),
      .blocked       (blocked),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .action        (action),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .next_state    (next_state),
      .reward        (reward),
      .terminal      (terminal),
      .timeout       (timeout),
      .cfg_err       (cfg_err),
      .episode_count (episode_count),
      .cur_state     (cur_state)
   );

   typedef struct {
      int ns;
      int rw;
      int term;
      int to;
      int acc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_chk  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   logic prev_ov = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: latency on the rising out_valid, result compare on each output handshake.
   always @(negedge clk) begin
      if (out_valid && !prev_ov && sb.size() > 0) check("latency", cyc, sb[0].acc + 2);
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("next_state", int'(next_state), mon_e.ns);
            check("reward", int'(reward), mon_e.rw);
            check("terminal", int'(terminal), mon_e.term);
            check("timeout", int'(timeout), mon_e.to);
         end
      end
      prev_ov = out_valid;
   end

   task automatic issue(input int a, input int ns, input int rw, input int term, input int to);
      int   w;
      exp_t e;
      @(posedge clk);
      #1;
      action   = 2'(a);
      in_valid = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!in_ready && w < 20);
      if (!in_ready) begin
         check("accept_wait", 0, 1);
         in_valid = 1'b0;
         return;
      end
      e.ns = ns; e.rw = rw; e.term = term; e.to = to; e.acc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (sb.size() != 0) begin
         check("result_wait", 0, 1);
         sb.delete();
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step(input int a, input int ns, input int rw, input int term, input int to);
      issue(a, ns, rw, term, to);
      drain();
   endtask

   task automatic episode(input int s);
      @(posedge clk);
      #1;
      ep_start    = 1'b1;
      start_state = SW'(s);
      @(negedge clk);
      check("in_ready_during_ep_start", int'(in_ready), 0);
      @(posedge clk);
      #1;
      ep_start = 1'b0;
   endtask

   task automatic wait_out_valid();
      int w;
      w = 0;
      while (!out_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!out_valid) check("out_valid_wait", 0, 1);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b0;
      ep_start     = 1'b0;
      start_state  = SW'(1);
      target_state = SW'(36);
      blocked      = '0;
      in_valid     = 1'b0;
      action       = 2'd0;
      out_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_cur_state", int'(cur_state), 0);
      check("rst_next_state", int'(next_state), 0);
      check("rst_reward", int'(reward), 0);
      check("rst_terminal", int'(terminal), 0);
      check("rst_cfg_err", int'(cfg_err), 0);
      check("rst_episode_count", int'(episode_count), 0);

      // Unloaded agent
      step(1, 0, -10, 0, 0);
      check("unloaded_cur_state", int'(cur_state), 0);

      // First move and row-end wall
      episode(1);
      check("ep_cur_state", int'(cur_state), 1);
      step(1, 2, -1, 0, 0);
      check("cur_after_right", int'(cur_state), 2);
      for (int i = 3; i <= 6; i++) step(1, i, -1, 0, 0);
      step(1, 6, -10, 0, 0);
      check("no_row_wrap", int'(cur_state), 6);
      step(0, 12, -1, 0, 0);

      // Edge and blocked-cell walls
      episode(1);
      step(3, 1, -10, 0, 0);
      step(1, 2, -1, 0, 0);
      step(2, 2, -10, 0, 0);
      step(0, 8, -1, 0, 0);
      blocked = '0;
      blocked[13] = 1'b1;
      step(0, 8, -10, 0, 0);
      check("blocked_cur_state", int'(cur_state), 8);
      step(3, 7, -1, 0, 0);
      step(3, 7, -10, 0, 0);
      blocked = '0;

      // Goal
      episode(1);
      step(0, 7, -1, 0, 0);
      step(0, 13, -1, 0, 0);
      step(0, 19, -1, 0, 0);
      step(0, 25, -1, 0, 0);
      for (int i = 26; i <= 30; i++) step(1, i, -1, 0, 0);
      step(0, 36, 100, 1, 0);
      check("goal_episode_count", int'(episode_count), 1);
      check("goal_restart", int'(cur_state), 1);

      // Timeout on step MS: alternate right/left between cells 1 and 2
      episode(1);
      for (int i = 1; i <= MS; i++) begin
         if (i % 2 == 1) step(1, 2, -1, 0, 0);
         else            step(3, 1, -1, (i == MS) ? 1 : 0, (i == MS) ? 1 : 0);
      end
      check("timeout_episode_count", int'(episode_count), 2);
      check("timeout_restart", int'(cur_state), 1);

      // Back-pressure: result held, ep_start ignored while in RESP
      out_ready = 1'b0;
      issue(1, 2, -1, 0, 0);
      wait_out_valid();
      for (int i = 0; i < 5; i++) begin
         if (i == 3) begin
            ep_start    = 1'b1;
            start_state = SW'(5);
         end
         check("stall_out_valid", int'(out_valid), 1);
         check("stall_in_ready", int'(in_ready), 0);
         check("stall_next_state", int'(next_state), 2);
         check("stall_reward", int'(reward), -1);
         @(negedge clk);
      end
      ep_start    = 1'b0;
      start_state = SW'(1);
      out_ready   = 1'b1;
      drain();
      check("stall_cur_state", int'(cur_state), 2);

      // Invalid start cell
      episode(0);
      check("cfg_err_set", int'(cfg_err), 1);
      check("cfg_err_cur_state", int'(cur_state), 2);

      // Reset while a result is pending
      out_ready = 1'b0;
      issue(1, 3, -1, 0, 0);
      wait_out_valid();
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      sb.delete();
      check("rstresp_out_valid", int'(out_valid), 0);
      check("rstresp_next_state", int'(next_state), 0);
      check("rstresp_reward", int'(reward), 0);
      check("rstresp_cfg_err", int'(cfg_err), 0);
      check("rstresp_episode_count", int'(episode_count), 0);
      check("rstresp_cur_state", int'(cur_state), 0);
      rst       = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("rstresp_in_ready", int'(in_ready), 1);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
